// File: rtl/kyber_pke_enc.sv
// ---------------------------------------------------------------------------
// kyber_pke_enc -- input front-end of the Kyber (k=3) PKE encryption core.
//
// Requests the 32-byte randomness r, then the 1184-byte encapsulation key
// ek (1152 bytes of packed t followed by the 32-byte seed rho), and
// byte-decodes t into 3*N 12-bit coefficients held in an internal RAM.
// Downstream stages read r_mem, ek_mem (rho) and coeff_mem once done is high.
//
// Ports
//   clk             system clock, all logic on the rising edge
//   reset           synchronous, active-high reset
//   set             start request, honoured in IDLE and DONE only
//   readin          host presents kyber_din for address kyber_in_index
//   full_in         host has finished transferring the current data type
//   data_type[3:0]  type the host is presenting (1 = r, 2 = ek)
//   kyber_din[7:0]  input byte
//   kyber_in_index  byte address within the current data type
//   input_type[3:0] type requested by the core (0 = none, 1 = r, 2 = ek)
//   readin_ok       core accepts bytes this cycle
//   done            r and ek captured and t decoded; held until next start
// ---------------------------------------------------------------------------
module kyber_pke_enc #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        readin,
  input  logic        full_in,
  input  logic [3:0]  data_type,
  input  logic [7:0]  kyber_din,
  input  logic [15:0] kyber_in_index,
  output logic [3:0]  input_type,
  output logic        readin_ok,
  output logic        done
);

  localparam int N       = 1 << DEPTH;
  localparam int NCOEF   = 3 * N;
  localparam int TBYTES  = NCOEF * 3 / 2;
  localparam int EKBYTES = TBYTES + 32;
  localparam int CAW     = $clog2(NCOEF);
  localparam int EAW     = $clog2(EKBYTES);

  localparam logic [15:0]    R_LIMIT   = 16'd32;
  localparam logic [15:0]    EK_LIMIT  = 16'(EKBYTES);
  localparam logic [EAW-1:0] T_COUNT   = EAW'(TBYTES);
  localparam logic [EAW-1:0] T_LAST    = EAW'(TBYTES - 1);
  localparam logic [3:0]     TYPE_NONE = 4'd0;
  localparam logic [3:0]     TYPE_R    = 4'd1;
  localparam logic [3:0]     TYPE_EK   = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_R,
    S_LOAD_EK,
    S_DECODE,
    S_DONE
  } state_t;

  // Buffers are not reset; their contents are only meaningful once done is high.
  logic [7:0]  r_mem     [0:31];
  logic [7:0]  ek_mem    [0:EKBYTES-1];
  logic [11:0] coeff_mem [0:NCOEF-1];

  state_t         state_q, state_d;
  logic [3:0]     input_type_q, input_type_d;
  logic           readin_ok_q, readin_ok_d;
  logic           done_q, done_d;

  // Decode pipeline: rd_addr issues a RAM read, rd_data/rd_vld hold the byte
  // one cycle later, and phase tracks the byte's position in its 3-byte group.
  logic [EAW-1:0] rd_addr_q, rd_addr_d;
  logic           rd_vld_q, rd_vld_d;
  logic [7:0]     rd_data_q;
  logic [EAW-1:0] proc_cnt_q, proc_cnt_d;
  logic [1:0]     phase_q, phase_d;
  logic [CAW-1:0] coef_addr_q, coef_addr_d;
  logic [7:0]     b0_q, b0_d;
  logic [3:0]     b1_hi_q, b1_hi_d;

  logic           cap_en;
  logic           r_we, ek_we;
  logic           rd_issue;
  logic           coef_we;
  logic [11:0]    coef_wdata;

  assign input_type = input_type_q;
  assign readin_ok  = readin_ok_q;
  assign done       = done_q;

  // A byte is taken only when the host's type matches what the core is asking
  // for; the address bound silently drops anything past the buffer end.
  assign cap_en = readin & readin_ok_q & (data_type == input_type_q);
  assign r_we   = cap_en && (state_q == S_LOAD_R)  && (kyber_in_index < R_LIMIT);
  assign ek_we  = cap_en && (state_q == S_LOAD_EK) && (kyber_in_index < EK_LIMIT);

  assign rd_issue = (state_q == S_DECODE) && (rd_addr_q < T_COUNT);

  // Phase 1 completes the even coefficient (low nibble of the middle byte on
  // top of the first byte); phase 2 completes the odd one (last byte on top of
  // the middle byte's high nibble).
  assign coef_we    = rd_vld_q && (phase_q != 2'd0);
  assign coef_wdata = (phase_q == 2'd1) ? {rd_data_q[3:0], b0_q}
                                        : {rd_data_q, b1_hi_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (set) state_d = S_LOAD_R;
      S_LOAD_R:  if (full_in && (data_type == TYPE_R)) state_d = S_LOAD_EK;
      S_LOAD_EK: if (full_in && (data_type == TYPE_EK)) state_d = S_DECODE;
      S_DECODE:  if (rd_vld_q && (proc_cnt_q == T_LAST)) state_d = S_DONE;
      S_DONE:    if (set) state_d = S_LOAD_R;
      default:   state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    input_type_d = TYPE_NONE;
    readin_ok_d  = 1'b0;
    done_d       = 1'b0;
    case (state_d)
      S_LOAD_R: begin
        input_type_d = TYPE_R;
        readin_ok_d  = 1'b1;
      end
      S_LOAD_EK: begin
        input_type_d = TYPE_EK;
        readin_ok_d  = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase

    rd_addr_d   = rd_addr_q;
    rd_vld_d    = 1'b0;
    proc_cnt_d  = proc_cnt_q;
    phase_d     = phase_q;
    coef_addr_d = coef_addr_q;
    b0_d        = b0_q;
    b1_hi_d     = b1_hi_q;

    if (state_q == S_LOAD_EK) begin
      // Rearm the decoder so every run starts from byte 0.
      rd_addr_d   = '0;
      proc_cnt_d  = '0;
      phase_d     = 2'd0;
      coef_addr_d = '0;
    end else if (state_q == S_DECODE) begin
      rd_vld_d = rd_issue;
      if (rd_issue) rd_addr_d = rd_addr_q + 1'b1;
      if (rd_vld_q) begin
        proc_cnt_d = proc_cnt_q + 1'b1;
        phase_d    = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        if (phase_q == 2'd0) b0_d    = rd_data_q;
        if (phase_q == 2'd1) b1_hi_d = rd_data_q[7:4];
        if (coef_we) coef_addr_d = coef_addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      input_type_q <= TYPE_NONE;
      readin_ok_q  <= 1'b0;
      done_q       <= 1'b0;
      rd_addr_q    <= '0;
      rd_vld_q     <= 1'b0;
      proc_cnt_q   <= '0;
      phase_q      <= 2'd0;
      coef_addr_q  <= '0;
      b0_q         <= 8'd0;
      b1_hi_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      input_type_q <= input_type_d;
      readin_ok_q  <= readin_ok_d;
      done_q       <= done_d;
      rd_addr_q    <= rd_addr_d;
      rd_vld_q     <= rd_vld_d;
      proc_cnt_q   <= proc_cnt_d;
      phase_q      <= phase_d;
      coef_addr_q  <= coef_addr_d;
      b0_q         <= b0_d;
      b1_hi_q      <= b1_hi_d;
    end
  end

  // RAMs: no reset, synchronous write, registered read for ek_mem.
  always_ff @(posedge clk) begin
    if (r_we) r_mem[kyber_in_index[4:0]] <= kyber_din;
  end

  always_ff @(posedge clk) begin
    if (ek_we) ek_mem[kyber_in_index[EAW-1:0]] <= kyber_din;
    if (rd_issue) rd_data_q <= ek_mem[rd_addr_q];
  end

  always_ff @(posedge clk) begin
    if (coef_we && !reset) coeff_mem[coef_addr_q] <= coef_wdata;
  end

endmodule

// File: tb/tb_kyber_pke_enc.sv
// ---------------------------------------------------------------------------
// tb_kyber_pke_enc -- self-checking bench for kyber_pke_enc.
// Keeps its own copies of r and ek, predicts each coefficient by reading the
// ek byte string as a little-endian bit stream (12 bits per coefficient), and
// compares against the core's outputs and internal buffers.
// ---------------------------------------------------------------------------
module tb_kyber_pke_enc;

  logic        clk = 1'b0;
  logic        reset;
  logic        set;
  logic        readin;
  logic        full_in;
  logic [3:0]  data_type;
  logic [7:0]  kyber_din;
  logic [15:0] kyber_in_index;
  logic [3:0]  input_type;
  logic        readin_ok;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [7:0] r_ref  [32];
  logic [7:0] ek_ref [1184];

  kyber_pke_enc dut (
    .clk            (clk),
    .reset          (reset),
    .set            (set),
    .readin         (readin),
    .full_in        (full_in),
    .data_type      (data_type),
    .kyber_din      (kyber_din),
    .kyber_in_index (kyber_in_index),
    .input_type     (input_type),
    .readin_ok      (readin_ok),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] t, input int idx, input logic [7:0] d, input logic fin);
    readin         = 1'b1;
    data_type      = t;
    kyber_in_index = idx[15:0];
    kyber_din      = d;
    full_in        = fin;
    tick();
    readin  = 1'b0;
    full_in = 1'b0;
  endtask

  // Coefficient j is bits [12j, 12j+11] of the t byte string, LSB-first.
  function automatic logic [11:0] ref_coeff(input int j);
    logic [11:0] v;
    int p;
    v = '0;
    for (int b = 0; b < 12; b++) begin
      p = 12 * j + b;
      v[b] = ek_ref[p / 8][p % 8];
    end
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (input_type !== 4'd0 || readin_ok !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got type=%0d ok=%0b done=%0b want 0/0/0", input_type, readin_ok, done);
    end
    // No start request, and a stray full_in, must leave the core idle.
    full_in   = 1'b1;
    data_type = 4'd1;
    for (int i = 0; i < 5; i++) tick();
    full_in = 1'b0;
    total++;
    if (input_type !== 4'd0 || readin_ok !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold got type=%0d ok=%0b want 0/0", input_type, readin_ok);
    end
    $display("test_reset: checks so far=%0d", total);
  endtask

  task automatic test_load_r();
    int idx;
    set = 1'b1;
    tick();
    set = 1'b0;
    total++;
    if (input_type !== 4'd1 || readin_ok !== 1'b1) begin
      bad++;
      $display("FAIL start_r got type=%0d ok=%0b want 1/1", input_type, readin_ok);
    end
    for (int i = 0; i < 32; i++) begin
      r_ref[i] = 8'($urandom);
      put(4'd1, i, r_ref[i], 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      idx = int'($urandom_range(0, 31));
      r_ref[idx] = 8'($urandom);
      put(4'd1, idx, r_ref[idx], 1'b0);
    end
    // Wrong type: byte and full_in both ignored.
    put(4'd2, 5, ~r_ref[5], 1'b1);
    total++;
    if (input_type !== 4'd1) begin
      bad++;
      $display("FAIL type_mismatch_advance got type=%0d want 1", input_type);
    end
    // Out-of-range index aliases slot 8 if the bound check is missing.
    put(4'd1, 40, ~r_ref[8], 1'b0);
    // Last byte together with full_in: write lands, then state advances.
    r_ref[31] = 8'($urandom);
    put(4'd1, 31, r_ref[31], 1'b1);
    total++;
    if (input_type !== 4'd2 || readin_ok !== 1'b1) begin
      bad++;
      $display("FAIL r_to_ek got type=%0d ok=%0b want 2/1", input_type, readin_ok);
    end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (dut.r_mem[i] !== r_ref[i]) begin
        bad++;
        $display("FAIL r_mem[%0d] got=%02h want=%02h", i, dut.r_mem[i], r_ref[i]);
      end
    end
    $display("test_load_r: checks so far=%0d", total);
  endtask

  task automatic test_load_ek_decode();
    int n;
    int errs;
    int idx;
    for (int i = 0; i < 1184; i++) begin
      ek_ref[i] = 8'($urandom);
      put(4'd2, i, ek_ref[i], 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      idx = int'($urandom_range(0, 1183));
      ek_ref[idx] = 8'($urandom);
      put(4'd2, idx, ek_ref[idx], 1'b0);
    end
    put(4'd1, 7, ~ek_ref[7], 1'b1);
    total++;
    if (input_type !== 4'd2) begin
      bad++;
      $display("FAIL ek_type_mismatch got type=%0d want 2", input_type);
    end
    put(4'd2, 3000, ~ek_ref[952], 1'b0);
    data_type = 4'd2;
    full_in   = 1'b1;
    tick();
    full_in = 1'b0;
    total++;
    if (input_type !== 4'd0 || readin_ok !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL ek_exit got type=%0d ok=%0b done=%0b want 0/0/0", input_type, readin_ok, done);
    end
    // During decode: set, full_in and a write attempt must all be ignored.
    n = 0;
    while (!done && n < 2000) begin
      set            = (n == 50);
      full_in        = (n == 60);
      readin         = (n == 70);
      kyber_in_index = 16'd10;
      kyber_din      = ~ek_ref[10];
      tick();
      n++;
    end
    set     = 1'b0;
    full_in = 1'b0;
    readin  = 1'b0;
    total++;
    if (n != 1153) begin
      bad++;
      $display("FAIL done_latency got=%0d cycles want=1153", n);
    end
    errs = 0;
    for (int i = 0; i < 1184; i++) begin
      total++;
      if (dut.ek_mem[i] !== ek_ref[i]) begin
        bad++;
        errs++;
        if (errs < 10) $display("FAIL ek_mem[%0d] got=%02h want=%02h", i, dut.ek_mem[i], ek_ref[i]);
      end
    end
    for (int j = 0; j < 768; j++) begin
      total++;
      if (dut.coeff_mem[j] !== ref_coeff(j)) begin
        bad++;
        errs++;
        if (errs < 20) $display("FAIL coeff[%0d] got=%03h want=%03h", j, dut.coeff_mem[j], ref_coeff(j));
      end
    end
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (done !== 1'b1 || input_type !== 4'd0) begin
      bad++;
      $display("FAIL done_hold got done=%0b type=%0d want 1/0", done, input_type);
    end
    $display("test_load_ek_decode: latency=%0d checks so far=%0d", n, total);
  endtask

  task automatic test_back_to_back_example();
    int n;
    int errs;
    set = 1'b1;
    tick();
    set = 1'b0;
    total++;
    if (done !== 1'b0 || input_type !== 4'd1) begin
      bad++;
      $display("FAIL restart got done=%0b type=%0d want 0/1", done, input_type);
    end
    r_ref[0] = 8'($urandom);
    put(4'd1, 0, r_ref[0], 1'b1);
    for (int i = 0; i < 1184; i++) ek_ref[i] = 8'($urandom);
    ek_ref[0]    = 8'h01;
    ek_ref[1]    = 8'h23;
    ek_ref[2]    = 8'h45;
    ek_ref[1149] = 8'hAB;
    ek_ref[1150] = 8'hCD;
    ek_ref[1151] = 8'hEF;
    for (int i = 0; i < 1183; i++) put(4'd2, i, ek_ref[i], 1'b0);
    put(4'd2, 1183, ek_ref[1183], 1'b1);
    total++;
    if (input_type !== 4'd0 || readin_ok !== 1'b0) begin
      bad++;
      $display("FAIL ek_exit2 got type=%0d ok=%0b want 0/0", input_type, readin_ok);
    end
    n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    total++;
    if (n != 1153) begin
      bad++;
      $display("FAIL done_latency2 got=%0d cycles want=1153", n);
    end
    total++;
    if (dut.coeff_mem[0] !== 12'h301) begin
      bad++;
      $display("FAIL coeff0 got=%03h want=301", dut.coeff_mem[0]);
    end
    total++;
    if (dut.coeff_mem[1] !== 12'h452) begin
      bad++;
      $display("FAIL coeff1 got=%03h want=452", dut.coeff_mem[1]);
    end
    total++;
    if (dut.coeff_mem[766] !== 12'hDAB) begin
      bad++;
      $display("FAIL coeff766 got=%03h want=dab", dut.coeff_mem[766]);
    end
    total++;
    if (dut.coeff_mem[767] !== 12'hEFC) begin
      bad++;
      $display("FAIL coeff767 got=%03h want=efc", dut.coeff_mem[767]);
    end
    total++;
    if (dut.ek_mem[1183] !== ek_ref[1183] || dut.r_mem[0] !== r_ref[0]) begin
      bad++;
      $display("FAIL write_with_full got ek=%02h r=%02h want ek=%02h r=%02h",
               dut.ek_mem[1183], dut.r_mem[0], ek_ref[1183], r_ref[0]);
    end
    errs = 0;
    for (int j = 0; j < 768; j++) begin
      total++;
      if (dut.coeff_mem[j] !== ref_coeff(j)) begin
        bad++;
        errs++;
        if (errs < 20) $display("FAIL coeff2[%0d] got=%03h want=%03h", j, dut.coeff_mem[j], ref_coeff(j));
      end
    end
    $display("test_back_to_back_example: latency=%0d checks so far=%0d", n, total);
  endtask

  task automatic test_midop_reset();
    int rose;
    set = 1'b1;
    tick();
    set = 1'b0;
    put(4'd1, 0, 8'h00, 1'b1);
    data_type = 4'd2;
    full_in   = 1'b1;
    tick();
    full_in = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (input_type !== 4'd0 || readin_ok !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midop_reset got type=%0d ok=%0b done=%0b want 0/0/0", input_type, readin_ok, done);
    end
    rose = 0;
    for (int i = 0; i < 1300; i++) begin
      tick();
      if (done === 1'b1 || input_type !== 4'd0) rose = 1;
    end
    total++;
    if (rose != 0) begin
      bad++;
      $display("FAIL midop_stays_idle got activity=%0d want 0", rose);
    end
    set = 1'b1;
    tick();
    set = 1'b0;
    total++;
    if (input_type !== 4'd1 || readin_ok !== 1'b1) begin
      bad++;
      $display("FAIL restart_after_reset got type=%0d ok=%0b want 1/1", input_type, readin_ok);
    end
    $display("test_midop_reset: checks so far=%0d", total);
  endtask

  initial begin
    reset          = 1'b1;
    set            = 1'b0;
    readin         = 1'b0;
    full_in        = 1'b0;
    data_type      = 4'd0;
    kyber_din      = 8'd0;
    kyber_in_index = 16'd0;
    test_reset();
    test_load_r();
    test_load_ek_decode();
    test_back_to_back_example();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
